reset_sequencer: RTL

Controller that sequences reset release for NUM_DOMAINS downstream reset domains built from asynchronously-reset registers. Assertion is asynchronous: all domain resets assert immediately on rst. Deassertion is synchronized to clk, then released one domain at a time, with a fixed gap and a per-domain ready handshake. Also supports a software-requested warm reset from the running state. Sits at the top of each clock domain, between the raw reset pin and the consumer blocks.

---
 rtl/reset_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: async assert, synchronized and ordered per-domain release.
// Optional RESET_SEQ_TIMEOUT_EN bounds each ready wait to TIMEOUT_CYCLES.
module reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int SYNC_STAGES    = 3,
    parameter int GAP_CYCLES     = 16,
    parameter int SW_HOLD_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_rst_req,
    input  logic [NUM_DOMAINS-1:0] domain_ready,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic [2:0]             seq_state,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [3:0]             fail_idx
);

    localparam int MAXA = (GAP_CYCLES > SW_HOLD_CYCLES) ?
                          GAP_CYCLES : SW_HOLD_CYCLES;
    localparam int MAXC = (MAXA > TIMEOUT_CYCLES) ? MAXA : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] SWH_LAST = CW'(SW_HOLD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        S_HOLD  = 3'd0,
        S_GAP   = 3'd1,
        S_WAIT  = 3'd2,
        S_RUN   = 3'd3,
        S_SWRST = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_ok;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0] drst_q, drst_d;
    logic                   adv;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic       terr_q, terr_d;
    logic [3:0] fidx_q, fidx_d;
`endif

    // Deassertion synchronizer: a short rst pulse still clears every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];

    // State register; domain resets are set asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HOLD;
            idx_q   <= '0;
            cnt_q   <= '0;
            drst_q  <= '1;
`ifdef RESET_SEQ_TIMEOUT_EN
            terr_q  <= 1'b0;
            fidx_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            drst_q  <= drst_d;
`ifdef RESET_SEQ_TIMEOUT_EN
            terr_q  <= terr_d;
            fidx_q  <= fidx_d;
`endif
        end
    end

    // Next-state logic: gap timing, ordered release, ready wait, warm reset.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        drst_d  = drst_q;
        adv     = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
        terr_d  = terr_q;
        fidx_d  = fidx_q;
`endif
        unique case (state_q)
            S_HOLD: begin
                if (sync_ok) begin
                    state_d = S_GAP;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    drst_d[idx_q] = 1'b0;
                    state_d       = S_WAIT;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
`ifdef RESET_SEQ_TIMEOUT_EN
                adv = domain_ready[idx_q] || (cnt_q == TMO_LAST);
                if (!domain_ready[idx_q] && (cnt_q == TMO_LAST)) begin
                    terr_d = 1'b1;
                    fidx_d = 4'(idx_q);
                end
                if (!adv) begin
                    cnt_d = cnt_q + CW'(1);
                end
`else
                adv = domain_ready[idx_q];
`endif
                if (adv) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_GAP;
                    end
                end
            end
            S_RUN: begin
                if (sw_rst_req) begin
                    state_d = S_SWRST;
                    drst_d  = '1;
                    cnt_d   = '0;
`ifdef RESET_SEQ_TIMEOUT_EN
                    terr_d  = 1'b0;
                    fidx_d  = 4'd0;
`endif
                end
            end
            S_SWRST: begin
                if (cnt_q == SWH_LAST) begin
                    state_d = S_GAP;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    assign domain_rst = drst_q;
    assign seq_state  = state_q;
    assign busy       = (state_q != S_RUN);
    assign done       = (state_q == S_RUN);

`ifdef RESET_SEQ_TIMEOUT_EN
    assign timeout_err = terr_q;
    assign fail_idx    = fidx_q;
`else
    assign timeout_err = 1'b0;
    assign fail_idx    = 4'd0;
`endif

endmodule
